// File: rtl/prog_ctr_pkg.sv
// prog_ctr_pkg: shared state encoding and default widths for the program counter stage.
package prog_ctr_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} pc_state_t;
    localparam int PC_W_DEF  = 10;
    localparam int LUT_W_DEF = 5;
endpackage

// File: rtl/prog_ctr_jump_lut.sv
// jump_lut: combinational ROM mapping an instruction immediate to a jump/branch target.
// Default contents place targets on 8-word boundaries; program-specific tables replace the case list.
module jump_lut
    import prog_ctr_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int LUT_W = LUT_W_DEF
) (
    input  logic [LUT_W-1:0] idx,
    output logic [PC_W-1:0]  target
);
    always_comb begin
        target = '0;
        case (idx)
            LUT_W'(0):  target = PC_W'(0);
            LUT_W'(1):  target = PC_W'(8);
            LUT_W'(2):  target = PC_W'(16);
            LUT_W'(3):  target = PC_W'(24);
            LUT_W'(4):  target = PC_W'(32);
            LUT_W'(5):  target = PC_W'(40);
            LUT_W'(6):  target = PC_W'(48);
            LUT_W'(7):  target = PC_W'(56);
            LUT_W'(8):  target = PC_W'(64);
            LUT_W'(9):  target = PC_W'(72);
            LUT_W'(10): target = PC_W'(80);
            LUT_W'(11): target = PC_W'(88);
            LUT_W'(12): target = PC_W'(96);
            LUT_W'(13): target = PC_W'(104);
            LUT_W'(14): target = PC_W'(112);
            LUT_W'(15): target = PC_W'(120);
            LUT_W'(16): target = PC_W'(128);
            LUT_W'(17): target = PC_W'(136);
            LUT_W'(18): target = PC_W'(144);
            LUT_W'(19): target = PC_W'(152);
            LUT_W'(20): target = PC_W'(160);
            LUT_W'(21): target = PC_W'(168);
            LUT_W'(22): target = PC_W'(176);
            LUT_W'(23): target = PC_W'(184);
            LUT_W'(24): target = PC_W'(192);
            LUT_W'(25): target = PC_W'(200);
            LUT_W'(26): target = PC_W'(208);
            LUT_W'(27): target = PC_W'(216);
            LUT_W'(28): target = PC_W'(224);
            LUT_W'(29): target = PC_W'(232);
            LUT_W'(30): target = PC_W'(240);
            LUT_W'(31): target = PC_W'(248);
            default:    target = '0;
        endcase
    end
endmodule

// File: rtl/prog_ctr.sv
// prog_ctr: program counter and branch-control stage with start/done handshake.
// All outputs come straight from registers; decoder inputs only act in RUN.
module prog_ctr
    import prog_ctr_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int LUT_W = LUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             alu_flag,
    input  logic             flag_we,
    input  logic             branch,
    input  logic             jump,
    input  logic [LUT_W-1:0] lut_idx,
    input  logic             halt,
    output logic [PC_W-1:0]  pc,
    output logic             flag_q,
    output logic             running,
    output logic             done
);
    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, target;
    logic            flag_r, flag_d;

    jump_lut #(.PC_W(PC_W), .LUT_W(LUT_W)) u_lut (
        .idx    (lut_idx),
        .target (target)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flag_d  = flag_r;
        case (state_q)
            IDLE, HALTED: begin
                state_d = start ? RUN : state_q;
                pc_d    = start ? '0 : pc_q;
                flag_d  = start ? 1'b0 : flag_r;
            end
            RUN: begin
                // branch decision uses the flag value from before this cycle's capture
                state_d = halt ? HALTED : RUN;
                pc_d    = halt ? pc_q : (jump || (branch && flag_r)) ? target : pc_q + PC_W'(1);
                flag_d  = (!halt && flag_we) ? alu_flag : flag_r;
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                flag_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            flag_r  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flag_r  <= flag_d;
        end
    end

    assign pc      = pc_q;
    assign flag_q  = flag_r;
    assign running = state_q == RUN;
    assign done    = state_q == HALTED;
endmodule
